// File: rtl/cache_memory.sv
// cache_memory: tag/valid/dirty/data storage of an N-way set-associative,
// write-back, write-allocate data cache. Lookup and victim selection are
// combinational; word writes, block refills, LRU ages and read data are
// registered. The cache controller sequences misses through the enables.
module cache_memory #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 64,
    parameter int NUM_WAYS        = 4,
    parameter int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE,
    parameter int NUM_SETS        = NUM_BLOCKS / NUM_WAYS,
    parameter int INDEX_WIDTH     = $clog2(NUM_SETS),
    parameter int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK),
    parameter int TAG_WIDTH       = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TAG_WIDTH-1:0]    tag,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic [OFFSET_WIDTH-1:0] blk_offset,
    input  logic                    req_type,
    input  logic                    read_en_cache,
    input  logic                    write_en_cache,
    input  logic                    read_en_mem,
    input  logic                    write_en_mem,
    input  logic [BLOCK_SIZE-1:0]   data_in_mem,
    input  logic [WORD_SIZE-1:0]    data_in,
    output logic [BLOCK_SIZE-1:0]   dirty_block_out,
    output logic                    hit,
    output logic [WORD_SIZE-1:0]    data_out,
    output logic                    dirty_bit
);

    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LINE_W   = BLOCK_SIZE + TAG_WIDTH + 2;
    localparam int BLOCK_LO = TAG_WIDTH + 2;

    // Line layout: {block, tag, dirty, valid}
    logic [LINE_W-1:0] cache [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]  age   [NUM_SETS][NUM_WAYS];

    logic [NUM_WAYS-1:0] way_valid;
    logic [NUM_WAYS-1:0] way_dirty;
    logic [NUM_WAYS-1:0] way_match;
    logic [WAY_W-1:0]    age_set  [NUM_WAYS];
    logic [WAY_W-1:0]    age_next [NUM_WAYS];

    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    invalid_way;
    logic                any_invalid;
    logic [WAY_W-1:0]    lru_way;
    logic [WAY_W-1:0]    lru_age;
    logic [WAY_W-1:0]    victim_way;
    logic [WAY_W-1:0]    accessed_way;

    logic [LINE_W-1:0]     victim_line;
    logic [LINE_W-1:0]     hit_line;
    logic [LINE_W-1:0]     write_line;
    logic [LINE_W-1:0]     refill_line;
    logic [BLOCK_SIZE-1:0] refill_block;
    logic [WORD_SIZE-1:0]  read_word;

    logic do_refill;
    logic do_write;
    logic do_read;
    logic lru_update;

    // Victim write-back is sequenced entirely by the controller.
    logic unused_write_en_mem;
    assign unused_write_en_mem = write_en_mem;

    // Per-way views of the indexed set and the ages after touching accessed_way
    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign way_valid[gi] = cache[index][gi][0];
            assign way_dirty[gi] = cache[index][gi][1];
            assign way_match[gi] = way_valid[gi] &&
                                   (cache[index][gi][TAG_WIDTH+1:2] == tag);
            assign age_set[gi]   = age[index][gi];
            assign age_next[gi]  = (WAY_W'(gi) == accessed_way) ? '0 :
                                   (age_set[gi] < age_set[accessed_way]) ?
                                   age_set[gi] + WAY_W'(1) : age_set[gi];
        end
    endgenerate

    assign hit = |way_match;

    // Hit way, lowest invalid way and oldest (LRU) way of the indexed set
    always_comb begin
        hit_way     = '0;
        invalid_way = '0;
        any_invalid = 1'b0;
        lru_way     = '0;
        lru_age     = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!way_valid[w]) begin
                any_invalid = 1'b1;
                invalid_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_set[w] > lru_age) begin
                lru_age = age_set[w];
                lru_way = WAY_W'(w);
            end
        end
        victim_way   = any_invalid ? invalid_way : lru_way;
        accessed_way = hit ? hit_way : victim_way;
    end

    // Write-back view of the victim; suppressed while the request hits
    always_comb begin
        victim_line     = cache[index][victim_way];
        dirty_bit       = !hit && victim_line[0] && victim_line[1];
        dirty_block_out = hit ? '0 : victim_line[LINE_W-1 -: BLOCK_SIZE];
    end

    // New line contents for refill (with optional write merge) and word write
    always_comb begin
        refill_block = data_in_mem;
        if (req_type) begin
            refill_block[blk_offset*WORD_SIZE +: WORD_SIZE] = data_in;
        end
        refill_line = {refill_block, tag, req_type, 1'b1};

        hit_line   = cache[index][hit_way];
        write_line = hit_line;
        write_line[BLOCK_LO + blk_offset*WORD_SIZE +: WORD_SIZE] = data_in;
        write_line[1] = 1'b1;
        read_word  = hit_line[BLOCK_LO + blk_offset*WORD_SIZE +: WORD_SIZE];
    end

    // Operation priority: refill, then write hit, then read hit
    assign do_refill  = write_en_cache && read_en_mem;
    assign do_write   = !do_refill && write_en_cache && req_type && hit;
    assign do_read    = !do_refill && !do_write && read_en_cache && !req_type && hit;
    assign lru_update = do_refill || do_write || do_read;

    // Line storage: refill goes to the accessed way (victim on a miss)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    cache[s][w] <= '0;
                end
            end
        end else if (do_refill) begin
            cache[index][accessed_way] <= refill_line;
        end else if (do_write) begin
            cache[index][hit_way] <= write_line;
        end
    end

    // LRU ages: touched way becomes youngest, younger ways age by one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age[s][w] <= WAY_W'(w);
                end
            end
        end else if (lru_update) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                age[index][w] <= age_next[w];
            end
        end
    end

    // Registered read data, held until the next read hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (do_read) begin
            data_out <= read_word;
        end
    end

endmodule

// File: tb/tb_cache_memory.sv
// tb_cache_memory: directed scenarios for cache_memory with hand-computed
// expected values; one task per scenario.
module tb_cache_memory;

    logic         clk;
    logic         rst_n;
    logic [25:0]  tag;
    logic [3:0]   index;
    logic [1:0]   blk_offset;
    logic         req_type;
    logic         read_en_cache;
    logic         write_en_cache;
    logic         read_en_mem;
    logic         write_en_mem;
    logic [127:0] data_in_mem;
    logic [31:0]  data_in;
    logic [127:0] dirty_block_out;
    logic         hit;
    logic [31:0]  data_out;
    logic         dirty_bit;

    int errors = 0;
    int checks = 0;

    cache_memory dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tag            (tag),
        .index          (index),
        .blk_offset     (blk_offset),
        .req_type       (req_type),
        .read_en_cache  (read_en_cache),
        .write_en_cache (write_en_cache),
        .read_en_mem    (read_en_mem),
        .write_en_mem   (write_en_mem),
        .data_in_mem    (data_in_mem),
        .data_in        (data_in),
        .dirty_block_out(dirty_block_out),
        .hit            (hit),
        .data_out       (data_out),
        .dirty_bit      (dirty_bit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one request at the falling edge; outputs settle 1 time unit later
    task automatic drive(input logic [25:0] t, input logic [3:0] idx,
                         input logic [1:0] off, input logic rt,
                         input logic rc, input logic wc, input logic rm,
                         input logic [127:0] dm, input logic [31:0] di);
        @(negedge clk);
        tag = t; index = idx; blk_offset = off; req_type = rt;
        read_en_cache = rc; write_en_cache = wc; read_en_mem = rm;
        write_en_mem = 1'b0; data_in_mem = dm; data_in = di;
        $display("txn tag=%h set=%0d off=%0d rt=%b rc=%b wc=%b rm=%b di=%h",
                 t, idx, off, rt, rc, wc, rm, di);
        #1;
    endtask

    // Commit the request on the rising edge, then drop the enables
    task automatic step();
        @(posedge clk);
        #1;
        read_en_cache = 1'b0; write_en_cache = 1'b0; read_en_mem = 1'b0;
    endtask

    task automatic refill(input logic [25:0] t, input logic [3:0] idx,
                          input logic rt, input logic [1:0] off,
                          input logic [127:0] dm, input logic [31:0] di);
        drive(t, idx, off, rt, 1'b0, 1'b1, 1'b1, dm, di);
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tag = '0; index = '0; blk_offset = '0; req_type = 1'b0;
        read_en_cache = 1'b0; write_en_cache = 1'b0; read_en_mem = 1'b0;
        write_en_mem = 1'b0; data_in_mem = '0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", hit); end
        checks++; if (dirty_bit !== 1'b0) begin errors++; $display("FAIL reset_dirty_bit: got %b want 0", dirty_bit); end
        checks++; if (dirty_block_out !== 128'h0) begin errors++; $display("FAIL reset_dirty_block: got %h want 0", dirty_block_out); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        checks++; if (dut.accessed_way !== 2'd0) begin errors++; $display("FAIL reset_victim: got %0d want 0", dut.accessed_way); end
    endtask

    task automatic test_read_hits();
        // way0 is loaded dirty by merging its own word 2 back in
        refill(26'h1ABCDE, 4'd0, 1'b1, 2'd2, 128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333, 32'hCCCC1111);
        refill(26'h2BCDEF, 4'd0, 1'b0, 2'd0, 128'h12345678_9ABCDEF0_0FEDCBA9_76543210, 32'h0);
        refill(26'h3CDEF0, 4'd0, 1'b0, 2'd0, 128'hFACEFACE_BEEFBEEF_DEADDEAD_CAFECAFE, 32'h0);
        refill(26'h4DEF01, 4'd0, 1'b0, 2'd0, 128'h11112222_33334444_55556666_77778888, 32'h0);

        drive(26'h1ABCDE, 4'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rd0_hit: got %b want 1", hit); end
        checks++; if (dirty_bit !== 1'b0) begin errors++; $display("FAIL rd0_dirty_bit_on_hit: got %b want 0", dirty_bit); end
        step();
        checks++; if (data_out !== 32'hCCCC1111) begin errors++; $display("FAIL rd0_data: got %h want CCCC1111", data_out); end

        drive(26'h3CDEF0, 4'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (dut.accessed_way !== 2'd2) begin errors++; $display("FAIL rd1_way: got %0d want 2", dut.accessed_way); end
        step();
        checks++; if (data_out !== 32'hDEADDEAD) begin errors++; $display("FAIL rd1_data: got %h want DEADDEAD", data_out); end

        drive(26'h4DEF01, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (dut.accessed_way !== 2'd3) begin errors++; $display("FAIL rd2_way: got %0d want 3", dut.accessed_way); end
        step();
        checks++; if (data_out !== 32'h77778888) begin errors++; $display("FAIL rd2_data: got %h want 77778888", data_out); end

        drive(26'h2BCDEF, 4'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (dut.accessed_way !== 2'd1) begin errors++; $display("FAIL rd3_way: got %0d want 1", dut.accessed_way); end
        step();
        checks++; if (data_out !== 32'h12345678) begin errors++; $display("FAIL rd3_data: got %h want 12345678", data_out); end
    endtask

    task automatic test_dirty_miss();
        drive(26'h1ABCD1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b want 0", hit); end
        checks++; if (dut.accessed_way !== 2'd0) begin errors++; $display("FAIL miss_victim: got %0d want 0", dut.accessed_way); end
        checks++; if (dirty_bit !== 1'b1) begin errors++; $display("FAIL miss_dirty_bit: got %b want 1", dirty_bit); end
        checks++; if (dirty_block_out !== 128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333) begin errors++; $display("FAIL miss_dirty_block: got %h want AAAABBBB_CCCC1111_DDDD2222_EEEE3333", dirty_block_out); end
        step();
        checks++; if (data_out !== 32'h12345678) begin errors++; $display("FAIL miss_data_hold: got %h want 12345678", data_out); end

        // write without refill data on a miss must leave everything alone
        drive(26'h1ABCD1, 4'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'hFFFFFFFF);
        step();
        drive(26'h1ABCD1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (hit !== 1'b0 || dut.accessed_way !== 2'd0) begin errors++; $display("FAIL miss_write_ignored: got hit=%b way=%0d want hit=0 way=0", hit, dut.accessed_way); end
        checks++; if (dirty_block_out !== 128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333) begin errors++; $display("FAIL miss_block_stable: got %h want AAAABBBB_CCCC1111_DDDD2222_EEEE3333", dirty_block_out); end
        step();

        refill(26'h1ABCD1, 4'd0, 1'b0, 2'd0, 128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321, 32'h0);
        drive(26'h1ABCD1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (hit !== 1'b1 || dut.accessed_way !== 2'd0) begin errors++; $display("FAIL refill_hit: got hit=%b way=%0d want hit=1 way=0", hit, dut.accessed_way); end
        step();
        checks++; if (data_out !== 32'h87654321) begin errors++; $display("FAIL refill_data: got %h want 87654321", data_out); end
        checks++; if (dut.cache[0][0][1] !== 1'b0) begin errors++; $display("FAIL refill_clean: got %b want 0", dut.cache[0][0][1]); end

        // ages are now way0=0 way1=1 way2=3 way3=2: evicted tag misses onto clean way2
        drive(26'h1ABCDE, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (hit !== 1'b0 || dut.accessed_way !== 2'd2) begin errors++; $display("FAIL lru_after_refill: got hit=%b way=%0d want hit=0 way=2", hit, dut.accessed_way); end
        checks++; if (dirty_bit !== 1'b0) begin errors++; $display("FAIL clean_victim_dirty_bit: got %b want 0", dirty_bit); end
        step();
    endtask

    task automatic test_compulsory();
        refill(26'h0000AA, 4'd1, 1'b1, 2'd0, 128'h0, 32'h11111111);
        drive(26'h333333, 4'd1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (hit !== 1'b0 || dut.accessed_way !== 2'd1) begin errors++; $display("FAIL comp_victim: got hit=%b way=%0d want hit=0 way=1", hit, dut.accessed_way); end
        checks++; if (dirty_bit !== 1'b0 || dirty_block_out !== 128'h0) begin errors++; $display("FAIL comp_dirty: got bit=%b block=%h want bit=0 block=0", dirty_bit, dirty_block_out); end
        step();
        refill(26'h333333, 4'd1, 1'b0, 2'd0, 128'h33333333_22222222_11111111_00000000, 32'h0);
        drive(26'h333333, 4'd1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (hit !== 1'b1 || dut.accessed_way !== 2'd1) begin errors++; $display("FAIL comp_reread_hit: got hit=%b way=%0d want hit=1 way=1", hit, dut.accessed_way); end
        step();
        checks++; if (data_out !== 32'h22222222) begin errors++; $display("FAIL comp_reread_data: got %h want 22222222", data_out); end
    endtask

    task automatic test_write_hit();
        refill(26'h111111, 4'd2, 1'b0, 2'd0, 128'h00000004_00000003_00000002_00000001, 32'h0);
        drive(26'h111111, 4'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h0BADF00D);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL wr_hit: got %b want 1", hit); end
        step();
        checks++; if (dut.cache[2][0][1] !== 1'b1) begin errors++; $display("FAIL wr_dirty: got %b want 1", dut.cache[2][0][1]); end
        drive(26'h111111, 4'd2, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        checks++; if (data_out !== 32'h0BADF00D) begin errors++; $display("FAIL wr_readback: got %h want 0BADF00D", data_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_words [3];
        exp_words[0] = 32'h00000001;
        exp_words[1] = 32'h00000002;
        exp_words[2] = 32'h00000003;
        for (int i = 0; i < 3; i++) begin
            drive(26'h111111, 4'd2, 2'(i), 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
            step();
            checks++; if (data_out !== exp_words[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, data_out, exp_words[i]); end
        end
    endtask

    task automatic test_dirty_evict();
        refill(26'h222222, 4'd2, 1'b0, 2'd0, 128'h22, 32'h0);
        refill(26'h333333, 4'd2, 1'b0, 2'd0, 128'h33, 32'h0);
        refill(26'h444444, 4'd2, 1'b0, 2'd0, 128'h44, 32'h0);
        drive(26'h555555, 4'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (hit !== 1'b0 || dut.accessed_way !== 2'd0) begin errors++; $display("FAIL evict_victim: got hit=%b way=%0d want hit=0 way=0", hit, dut.accessed_way); end
        checks++; if (dirty_bit !== 1'b1) begin errors++; $display("FAIL evict_dirty_bit: got %b want 1", dirty_bit); end
        checks++; if (dirty_block_out !== 128'h0BADF00D_00000003_00000002_00000001) begin errors++; $display("FAIL evict_block: got %h want 0BADF00D_00000003_00000002_00000001", dirty_block_out); end
        step();
    endtask

    task automatic test_reset_mid();
        int bad_lines;
        drive(26'h0ABCDE, 4'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 128'h5A5A, '0);
        rst_n = 1'b0;
        #1;
        tag = 26'h444444; index = 4'd2;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rstmid_hit: got %b want 0", hit); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rstmid_data_out: got %h want 0", data_out); end
        checks++; if (dirty_bit !== 1'b0) begin errors++; $display("FAIL rstmid_dirty_bit: got %b want 0", dirty_bit); end
        @(posedge clk);
        #1;
        read_en_cache = 1'b0; write_en_cache = 1'b0; read_en_mem = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        bad_lines = 0;
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) begin
                if (dut.cache[s][w][0] !== 1'b0) bad_lines++;
            end
        end
        checks++; if (bad_lines !== 0) begin errors++; $display("FAIL rstmid_valid: got %0d valid lines want 0", bad_lines); end
        drive(26'h0ABCDE, 4'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rstmid_refill_discarded: got %b want 0", hit); end
        step();
    endtask

    initial begin
        test_reset();
        test_read_hits();
        test_dirty_miss();
        test_compulsory();
        test_write_hit();
        test_back_to_back();
        test_dirty_evict();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
